// File: rtl/rf_pkg.sv
// rf_pkg: constants, FSM state type and pointer-width helper shared by the
// register file writeback arbiter and its grant logic.
package rf_pkg;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int ZERO_REG = 0;

    typedef enum logic {INIT, RUN} state_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rf_wb_grant.sv
// rf_wb_grant: combinational one-hot writeback grant. Round-robin starting after rr_ptr
// when RF_WB_ROUND_ROBIN_EN is defined, otherwise fixed priority (lowest index wins).
module rf_wb_grant import rf_pkg::*; #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]        valid,
`ifdef RF_WB_ROUND_ROBIN_EN
    input  logic [ptr_w(NUM_REQ)-1:0] rr_ptr,
`endif
    output logic [NUM_REQ-1:0]        grant
);
`ifdef RF_WB_ROUND_ROBIN_EN
    always_comb begin
        grant = '0;
        // farthest candidate first, so the nearest valid index after rr_ptr overwrites it
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (valid[(int'(rr_ptr) + k) % NUM_REQ])
                grant = NUM_REQ'(1) << ((int'(rr_ptr) + k) % NUM_REQ);
        end
    end
`else
    assign grant = valid & (~valid + NUM_REQ'(1));
`endif
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: zero-fills the register file after reset, then shares its write port
// among NUM_REQ requesters. Define RF_WB_ROUND_ROBIN_EN for round-robin arbitration.
module regfile_wb_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = rf_pkg::ADDR_W,
    parameter int DATA_W   = rf_pkg::DATA_W,
    parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_wb_addr,
    output logic [DATA_W-1:0]         rf_wb_data,
    output logic                      init_done
);
    import rf_pkg::*;

    state_t             state, state_next;
    logic [ADDR_W:0]    init_cnt;
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               xfer, last_init;

`ifdef RF_WB_ROUND_ROBIN_EN
    localparam int PTR_W = ptr_w(NUM_REQ);
    logic [PTR_W-1:0] rr_ptr, sel_idx;

    rf_wb_grant #(.NUM_REQ(NUM_REQ)) u_grant (.valid(req_valid), .rr_ptr(rr_ptr), .grant(grant));
`else
    rf_wb_grant #(.NUM_REQ(NUM_REQ)) u_grant (.valid(req_valid), .grant(grant));
`endif

    assign req_ready  = (state == RUN) ? grant : '0;
    assign xfer       = |req_ready;
    assign last_init  = init_cnt == (ADDR_W+1)'(NUM_REGS - 1);
    assign state_next = (state == INIT && last_init) ? RUN : state;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
`ifdef RF_WB_ROUND_ROBIN_EN
        sel_idx = '0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
`ifdef RF_WB_ROUND_ROBIN_EN
                sel_idx = PTR_W'(i);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= INIT;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_cnt   <= '0;
            rf_we      <= 1'b0;
            rf_wb_addr <= '0;
            rf_wb_data <= '0;
            init_done  <= 1'b0;
        end else if (state == INIT) begin
            init_cnt   <= init_cnt + 1'b1;
            rf_we      <= 1'b1;
            rf_wb_addr <= init_cnt[ADDR_W-1:0];
            rf_wb_data <= '0;
            init_done  <= last_init;
        end else begin
            // x0 is hardwired zero: the handshake completes but the write is dropped
            rf_we <= xfer && sel_addr != ADDR_W'(ZERO_REG);
            if (xfer) begin
                rf_wb_addr <= sel_addr;
                rf_wb_data <= sel_data;
            end
        end
    end

`ifdef RF_WB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    rr_ptr <= PTR_W'(NUM_REQ - 1);
        else if (xfer) rr_ptr <= sel_idx;
    end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized stimulus; expected writes and grants are
// queued by the driver and checked by a separate negedge monitor.
module tb_regfile_wb_arbiter;
    localparam int NR    = 2;
    localparam int NREGS = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [9:0]  req_addr = '0;
    logic [63:0] req_data = '0;
    logic        rf_we, init_done;
    logic [4:0]  rf_wb_addr;
    logic [31:0] rf_wb_data;

    int     n_cmp = 0, n_bad = 0;
    longint cyc = 0;

    typedef struct { longint tag; logic we; logic [4:0] addr; logic [31:0] data; logic done; } out_t;
    typedef struct { longint tag; logic [1:0] rdy; } rdy_t;
    out_t out_q[$];
    rdy_t rdy_q[$];
    out_t mo;
    rdy_t mr;

    int          init_left = 0;
    int          rr_last = NR - 1;
    logic [1:0]  pend = '0;
    logic [4:0]  p_addr[NR];
    logic [31:0] p_data[NR];

    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .rf_we(rf_we),
        .rf_wb_addr(rf_wb_addr), .rf_wb_data(rf_wb_data), .init_done(init_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, want);
        end
    endtask

    function automatic int model_grant(input logic [1:0] v);
`ifdef RF_WB_ROUND_ROBIN_EN
        for (int k = 1; k <= NR; k++) if (v[(rr_last + k) % NR]) return (rr_last + k) % NR;
`else
        for (int k = 0; k < NR; k++) if (v[k]) return k;
`endif
        return -1;
    endfunction

    always @(negedge clk) begin
        while (rdy_q.size() > 0 && rdy_q[0].tag <= cyc) begin
            mr = rdy_q.pop_front();
            chk("req_ready", 64'(req_ready), 64'(mr.rdy));
        end
        while (out_q.size() > 0 && out_q[0].tag <= cyc) begin
            mo = out_q.pop_front();
            chk("rf_we", 64'(rf_we), 64'(mo.we));
            chk("init_done", 64'(init_done), 64'(mo.done));
            if (mo.we) begin
                chk("rf_wb_addr", 64'(rf_wb_addr), 64'(mo.addr));
                chk("rf_wb_data", 64'(rf_wb_data), 64'(mo.data));
            end
        end
    end

    task automatic step(input logic [1:0] v, input logic [4:0] a0, a1,
                        input logic [31:0] d0, d1, output int g);
        out_t o;
        rdy_t r;
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        g = -1;
        r.tag = cyc;
        o.tag = cyc + 1;
        if (init_left > 0) begin
            r.rdy  = 2'b00;
            o.we   = 1'b1;
            o.addr = 5'(NREGS - init_left);
            o.data = '0;
            o.done = (init_left == 1);
            init_left--;
        end else begin
            g = model_grant(v);
            r.rdy  = (g < 0) ? 2'b00 : 2'(1 << g);
            o.addr = (g == 1) ? a1 : a0;
            o.data = (g == 1) ? d1 : d0;
            o.we   = (g >= 0) && o.addr != 5'd0;
            o.done = 1'b1;
            if (g >= 0) rr_last = g;
        end
        rdy_q.push_back(r);
        out_q.push_back(o);
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_step();
        int g;
        for (int i = 0; i < NR; i++) begin
            if (!pend[i] && $urandom_range(0, 2) != 0) begin
                pend[i]   = 1'b1;
                p_addr[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                p_data[i] = $urandom;
            end
        end
        step(pend, p_addr[0], p_addr[1], p_data[0], p_data[1], g);
        if (g >= 0) pend[g] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        rdy_q.delete();
        out_q.delete();
        reset = 1'b0;
        #1;
        chk("reset rf_we", 64'(rf_we), 64'd0);
        chk("reset rf_wb_addr", 64'(rf_wb_addr), 64'd0);
        chk("reset rf_wb_data", 64'(rf_wb_data), 64'd0);
        chk("reset init_done", 64'(init_done), 64'd0);
        chk("reset req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        init_left = NREGS;
        rr_last   = NR - 1;
        pend      = '0;
    endtask

    initial begin
        int g;
        #2;
        pulse_reset();
        repeat (10) rnd_step();
        pulse_reset();
        repeat (NREGS) step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, g);
        step(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0, g);
        step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, g);
        repeat (4) step(2'b11, 5'd1, 5'd2, 32'h1111_1111, 32'h2222_2222, g);
        step(2'b10, 5'd0, 5'd0, 32'd0, 32'h1234, g);
        step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, g);
        step(2'b01, 5'd3, 5'd0, 32'hA3, 32'd0, g);
        step(2'b01, 5'd4, 5'd0, 32'hA4, 32'd0, g);
        step(2'b01, 5'd5, 5'd0, 32'hA5, 32'd0, g);
        pulse_reset();
        repeat (300) rnd_step();
        step(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, g);
        @(negedge clk);
        #1;
        chk("scoreboard drained", 64'(out_q.size() + rdy_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
